// File: rtl/hicore_commit_multi_pkg.sv
// Shared HiCore commit definitions: default widths, FSM states and rob_info field layout.
// Each rob_info slot is packed as {pc, irq, excp}, with excp in the least significant bits.
package hicore_commit_multi_pkg;

  localparam int COMMIT_WIDTH_D = 2;
  localparam int REG_SIZE_D     = 32;
  localparam int PC_SIZE_D      = 32;
  localparam int RFIDX_WIDTH_D  = 5;
  localparam int CSRIDX_WIDTH_D = 12;
  localparam int EXCP_SIZE_D    = 8;
  localparam int IRQ_SIZE_D     = 3;
  localparam int FLUSH_HOLD_D   = 2;
  localparam int HOLD_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } commit_state_e;

  function automatic int info_width(input int pc_w, input int irq_w, input int excp_w);
    return pc_w + irq_w + excp_w;
  endfunction

  function automatic int excp_lsb(input int slot, input int info_w);
    return slot * info_w;
  endfunction

  function automatic int irq_lsb(input int slot, input int info_w, input int excp_w);
    return slot * info_w + excp_w;
  endfunction

  function automatic int pc_lsb(input int slot, input int info_w, input int excp_w,
                                input int irq_w);
    return slot * info_w + excp_w + irq_w;
  endfunction

endpackage

// File: rtl/hicore_commit_multi_if.sv
// Bus between the ROB / CSR unit (master) and the multi-slot commit stage (slave).
interface hicore_commit_multi_if
  import hicore_commit_multi_pkg::*;
#(
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_D,
  parameter int REG_SIZE     = REG_SIZE_D,
  parameter int PC_SIZE      = PC_SIZE_D,
  parameter int RFIDX_WIDTH  = RFIDX_WIDTH_D,
  parameter int CSRIDX_WIDTH = CSRIDX_WIDTH_D,
  parameter int EXCP_SIZE    = EXCP_SIZE_D,
  parameter int IRQ_SIZE     = IRQ_SIZE_D
);
  localparam int INFO_W = PC_SIZE + IRQ_SIZE + EXCP_SIZE;

  logic [COMMIT_WIDTH-1:0]              rob_ready;
  logic [COMMIT_WIDTH-1:0]              rob_valid;
  logic [COMMIT_WIDTH-1:0]              rob_rd_need;
  logic [COMMIT_WIDTH*RFIDX_WIDTH-1:0]  rob_rd_idx;
  logic [COMMIT_WIDTH*REG_SIZE-1:0]     rob_rd_data;
  logic [COMMIT_WIDTH-1:0]              rob_csr_need;
  logic [COMMIT_WIDTH*CSRIDX_WIDTH-1:0] rob_csr_idx;
  logic [COMMIT_WIDTH*REG_SIZE-1:0]     rob_csr_data;
  logic [COMMIT_WIDTH-1:0]              rob_fence_i_op;
  logic [COMMIT_WIDTH-1:0]              rob_mret_op;
  logic [COMMIT_WIDTH*PC_SIZE-1:0]      rob_next_pc;
  logic [COMMIT_WIDTH*INFO_W-1:0]       rob_info;

  logic                    csr_valid;
  logic [EXCP_SIZE-1:0]    csr_excp;
  logic [IRQ_SIZE-1:0]     csr_irq;
  logic [PC_SIZE-1:0]      csr_pc;
  logic [PC_SIZE-1:0]      csr_next_pc;
  logic                    csr_csr_need;
  logic [CSRIDX_WIDTH-1:0] csr_csr_idx;
  logic [REG_SIZE-1:0]     csr_csr_data;
  logic                    csr_mret_op;
  logic [IRQ_SIZE-1:0]     csr_irq_msk;
  logic [REG_SIZE-1:0]     csr_mepc;
  logic [REG_SIZE-1:0]     csr_mtvec;

  logic [COMMIT_WIDTH-1:0]             reg_wen;
  logic [COMMIT_WIDTH*RFIDX_WIDTH-1:0] reg_rd_idx;
  logic [COMMIT_WIDTH*REG_SIZE-1:0]    reg_rd_data;

  logic               flush;
  logic [PC_SIZE-1:0] flush_pc;
  logic [63:0]        instret;

  modport master (
    output rob_ready, rob_rd_need, rob_rd_idx, rob_rd_data, rob_csr_need, rob_csr_idx,
           rob_csr_data, rob_fence_i_op, rob_mret_op, rob_next_pc, rob_info,
           csr_irq_msk, csr_mepc, csr_mtvec,
    input  rob_valid, csr_valid, csr_excp, csr_irq, csr_pc, csr_next_pc, csr_csr_need,
           csr_csr_idx, csr_csr_data, csr_mret_op, reg_wen, reg_rd_idx, reg_rd_data,
           flush, flush_pc, instret
  );

  modport slave (
    input  rob_ready, rob_rd_need, rob_rd_idx, rob_rd_data, rob_csr_need, rob_csr_idx,
           rob_csr_data, rob_fence_i_op, rob_mret_op, rob_next_pc, rob_info,
           csr_irq_msk, csr_mepc, csr_mtvec,
    output rob_valid, csr_valid, csr_excp, csr_irq, csr_pc, csr_next_pc, csr_csr_need,
           csr_csr_idx, csr_csr_data, csr_mret_op, reg_wen, reg_rd_idx, reg_rd_data,
           flush, flush_pc, instret
  );

endinterface

// File: rtl/hicore_commit_slot_sel.sv
// Combinational retire-mask, same-cycle WAW write-enable filter and instret popcount.
module hicore_commit_slot_sel #(
  parameter int COMMIT_WIDTH = 2,
  parameter int RFIDX_WIDTH  = 5,
  localparam int CNT_W       = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                            run_i,
  input  logic [COMMIT_WIDTH-1:0]         ready_i,
  input  logic [COMMIT_WIDTH-1:0]         serial_i,
  input  logic [COMMIT_WIDTH-1:0]         no_wb_i,
  input  logic [COMMIT_WIDTH-1:0]         rd_need_i,
  input  logic [COMMIT_WIDTH*RFIDX_WIDTH-1:0] rd_idx_i,
  output logic [COMMIT_WIDTH-1:0]         retire_o,
  output logic [COMMIT_WIDTH-1:0]         wen_o,
  output logic [CNT_W-1:0]                count_o
);

  logic                    blocked;
  logic [COMMIT_WIDTH-1:0] writes;

  // Retirement stops at the first not-ready slot; a serialising slot may only lead the group.
  always_comb begin
    retire_o = '0;
    blocked  = !run_i;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!blocked && ready_i[i] && (i == 0 || !serial_i[i])) begin
        retire_o[i] = 1'b1;
        if (serial_i[i]) blocked = 1'b1;
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_comb begin
    writes  = '0;
    wen_o   = '0;
    count_o = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      writes[i] = retire_o[i] && rd_need_i[i] && !no_wb_i[i] &&
                  (rd_idx_i[i*RFIDX_WIDTH +: RFIDX_WIDTH] != '0);
      count_o   = count_o + CNT_W'(retire_o[i] && !no_wb_i[i]);
    end
    // The youngest writer of a register wins; older writers of the same rd are dropped.
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      wen_o[i] = writes[i];
      for (int k = i + 1; k < COMMIT_WIDTH; k++) begin
        if (writes[k] &&
            rd_idx_i[k*RFIDX_WIDTH +: RFIDX_WIDTH] == rd_idx_i[i*RFIDX_WIDTH +: RFIDX_WIDTH])
          wen_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hicore_commit_multi.sv
// In-order multi-slot retirement stage: regfile write ports, serialising CSR hand-off,
// registered flush with programmable hold, and a 64-bit retired-instruction counter.
module hicore_commit_multi
  import hicore_commit_multi_pkg::*;
#(
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_D,
  parameter int REG_SIZE     = REG_SIZE_D,
  parameter int PC_SIZE      = PC_SIZE_D,
  parameter int RFIDX_WIDTH  = RFIDX_WIDTH_D,
  parameter int CSRIDX_WIDTH = CSRIDX_WIDTH_D,
  parameter int EXCP_SIZE    = EXCP_SIZE_D,
  parameter int IRQ_SIZE     = IRQ_SIZE_D,
  parameter int FLUSH_HOLD   = FLUSH_HOLD_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hicore_commit_multi_if.slave cmt_if
);

  localparam int INFO_W = info_width(PC_SIZE, IRQ_SIZE, EXCP_SIZE);
  localparam int CNT_W  = $clog2(COMMIT_WIDTH + 1);

  commit_state_e           state_q, state_d;
  logic [HOLD_CNT_W-1:0]   hold_q, hold_d;
  logic [PC_SIZE-1:0]      flush_pc_q, flush_pc_d;
  logic [63:0]             instret_q, instret_d;

  logic [COMMIT_WIDTH-1:0][EXCP_SIZE-1:0] slot_excp;
  logic [IRQ_SIZE-1:0]     irq0;
  logic [PC_SIZE-1:0]      pc0;
  logic                    irq_hit;
  logic [COMMIT_WIDTH-1:0] slot_serial;
  logic [COMMIT_WIDTH-1:0] slot_no_wb;
  logic [COMMIT_WIDTH-1:0] retire;
  logic [COMMIT_WIDTH-1:0] wen;
  logic [CNT_W-1:0]        count;
  logic                    flush_cause;
  logic [PC_SIZE-1:0]      flush_target;
  logic                    unused_slot_bits;

  // Interrupts are taken only on the oldest slot; younger slots' IRQ bits never matter.
  always_comb begin
    irq0    = cmt_if.rob_info[irq_lsb(0, INFO_W, EXCP_SIZE) +: IRQ_SIZE];
    pc0     = cmt_if.rob_info[pc_lsb(0, INFO_W, EXCP_SIZE, IRQ_SIZE) +: PC_SIZE];
    irq_hit = |(irq0 & cmt_if.csr_irq_msk);
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      slot_excp[i]   = cmt_if.rob_info[excp_lsb(i, INFO_W) +: EXCP_SIZE];
      slot_no_wb[i]  = |slot_excp[i];
      slot_serial[i] = (|slot_excp[i]) | cmt_if.rob_csr_need[i] |
                       cmt_if.rob_fence_i_op[i] | cmt_if.rob_mret_op[i];
    end
    slot_no_wb[0]  = slot_no_wb[0] | irq_hit;
    slot_serial[0] = slot_serial[0] | irq_hit;
  end

  hicore_commit_slot_sel #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .RFIDX_WIDTH  (RFIDX_WIDTH)
  ) u_slot_sel (
    .run_i     (state_q == ST_RUN),
    .ready_i   (cmt_if.rob_ready),
    .serial_i  (slot_serial),
    .no_wb_i   (slot_no_wb),
    .rd_need_i (cmt_if.rob_rd_need),
    .rd_idx_i  (cmt_if.rob_rd_idx),
    .retire_o  (retire),
    .wen_o     (wen),
    .count_o   (count)
  );

  always_comb begin
    flush_cause = retire[0] &
                  ((|slot_excp[0]) | irq_hit | cmt_if.rob_fence_i_op[0] | cmt_if.rob_mret_op[0]);
    if ((|slot_excp[0]) | irq_hit)
      flush_target = PC_SIZE'(cmt_if.csr_mtvec);
    else if (cmt_if.rob_fence_i_op[0])
      flush_target = cmt_if.rob_next_pc[PC_SIZE-1:0];
    else
      flush_target = PC_SIZE'(cmt_if.csr_mepc);
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    flush_pc_d = flush_pc_q;
    instret_d  = instret_q + 64'(count);
    unique case (state_q)
      ST_RUN: begin
        if (flush_cause) begin
          state_d    = ST_FLUSH;
          flush_pc_d = flush_target;
        end
      end
      ST_FLUSH: begin
        if (FLUSH_HOLD == 0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
          hold_d  = HOLD_CNT_W'(FLUSH_HOLD);
        end
      end
      ST_HOLD: begin
        if (hold_q <= HOLD_CNT_W'(1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      hold_q     <= '0;
      flush_pc_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      flush_pc_q <= flush_pc_d;
      instret_q  <= instret_d;
    end
  end

  assign cmt_if.rob_valid    = retire;
  assign cmt_if.reg_wen      = wen;
  assign cmt_if.reg_rd_idx   = cmt_if.rob_rd_idx;
  assign cmt_if.reg_rd_data  = cmt_if.rob_rd_data;

  assign cmt_if.csr_valid    = retire[0] & slot_serial[0];
  assign cmt_if.csr_excp     = slot_excp[0];
  assign cmt_if.csr_irq      = irq0 & cmt_if.csr_irq_msk;
  assign cmt_if.csr_pc       = pc0;
  assign cmt_if.csr_next_pc  = cmt_if.rob_next_pc[PC_SIZE-1:0];
  assign cmt_if.csr_csr_need = cmt_if.csr_valid & cmt_if.rob_csr_need[0];
  assign cmt_if.csr_csr_idx  = cmt_if.rob_csr_idx[CSRIDX_WIDTH-1:0];
  assign cmt_if.csr_csr_data = cmt_if.rob_csr_data[REG_SIZE-1:0];
  assign cmt_if.csr_mret_op  = cmt_if.csr_valid & cmt_if.rob_mret_op[0];

  assign cmt_if.flush        = (state_q == ST_FLUSH);
  assign cmt_if.flush_pc     = flush_pc_q;
  assign cmt_if.instret      = instret_q;

  // Younger slots' CSR/PC fields are deliberately not consumed.
  assign unused_slot_bits = ^{cmt_if.rob_info, cmt_if.rob_next_pc, cmt_if.rob_csr_idx,
                              cmt_if.rob_csr_data, cmt_if.csr_mepc, cmt_if.csr_mtvec};

endmodule
